serial_subtractor: RTL

//   Bit-serial full subtractor: computes diff = a - b - bin over WIDTH bits,
//   LSB first, one bit per clock, through a single full-subtractor cell
//   (two half subtractors plus an OR) and a borrow flip-flop. It is the

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial full subtractor with start/done handshake
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_result;
  logic             r_borrow;
  logic [CW-1:0]    r_count;

  logic w_x;
  logic w_y;
  logic w_hs1_d;
  logic w_hs1_b;
  logic w_hs2_b;
  logic w_d;
  logic w_borrow_next;
  logic w_load;
  logic w_shift;
  logic w_last_bit;

  // Single full-subtractor cell built from two half subtractors and an OR.
  assign w_x           = r_a_sr[0];
  assign w_y           = r_b_sr[0];
  assign w_hs1_d       = w_x ^ w_y;
  assign w_hs1_b       = ~w_x & w_y;
  assign w_d           = w_hs1_d ^ r_borrow;
  assign w_hs2_b       = ~w_hs1_d & r_borrow;
  assign w_borrow_next = w_hs1_b | w_hs2_b;

  // A new operation may be accepted from IDLE or from the DONE cycle.
  assign w_load     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_shift    = (r_state == S_SHIFT);
  assign w_last_bit = (r_count == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last_bit) w_state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        w_state_next = start ? S_SHIFT : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand shift registers, borrow flop, bit counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_result <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
    end else if (w_load) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_borrow <= bin;
      r_count  <= '0;
    end else if (w_shift) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_result <= (r_result >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
      r_borrow <= w_borrow_next;
      r_count  <= r_count + CW'(1);
    end
  end

  // Result and borrow-out hold between operations.
  assign diff = r_result;
  assign bout = r_borrow;

endmodule
